z3_slave_engine: RTL and testbench
==================================

# z3_slave_engine

Parametrised Zorro III slave cycle engine for the A4092 family, clocked directly from CLK_50M. It claims Zorro III cycles that fall in the configured board window and decodes them onto NUM_TGT local target channels (ROM, SCSI, SID, INTREG, future blocks) through a common req/ack handshake. It drives SLAVE_n, DTACK and MTACK, and terminates hung targets with a timeout. It replaces the fixed, per-target DTACK OR-tree in the top level.

## Interface
Parameters:
- NUM_TGT, 4, number of target channels (1–8)
- SYNC_STAGES, 2, synchroniser depth for FCS_n, DS_n, MTCR_n (≥2)
- TIMEOUT_CYC, 255, CLK_50M cycles allowed between tgt_req and tgt_ack (1–1023)

Ports:
- CLK_50M  in  1  engine clock
- IORST_n  in  1  reset (asynchronous, active-low)
- FCS_n  in  1  Zorro full cycle strobe, asynchronous
- A  in  32  Zorro address bus
- FC  in  3  function codes
- READ  in  1  Zorro read/write
- DOE  in  1  Zorro data output enable
- DS_n  in  4  Zorro data strobes, asynchronous
- MTCR_n  in  1  multi-transfer cycle strobe, asynchronous
- configured  in  1  autoconfig complete
- base_addr  in  4  board base A[31:28] from autoconfig
- SLAVE_n  out  1  board responding
- DTACK_OE  out  1  drive DTACK_n low (pad is tri-stated otherwise)
- MTACK_n  out  1  multi-transfer acknowledge
- tgt_sel  out  NUM_TGT  one-hot selected target
- tgt_req  out  1  transfer request, level
- tgt_we  out  1  write (=!READ latched)
- tgt_addr  out  28  board offset {ADDR[27:8], A[7:2], 2'b00}
- tgt_be  out  4  byte enables (inverted synchronised DS_n, frozen at request)
- tgt_ack  in  NUM_TGT  per-target completion, level, sampled on CLK_50M
- timeout_flag  out  1  sticky timeout status
- timeout_clr  in  1  clears timeout_flag
- busy  out  1  state ≠ IDLE

## Operation
- A[31:8] is captured by flops clocked on FCS_n falling edge and cleared by IORST_n. The window match (A[31:28]==base_addr && configured && FC[1]^FC[0]) is captured at the same edge. A[7:2] is sampled live.
- Target decode: first i (lowest index wins) with (ADDR[27:20] & TGT_MASK[i]) == TGT_BASE[i]. No match → cycle not claimed; engine stays IDLE.
- States:
  - IDLE: on sync FCS low && window match && decode hit → ADDR; latch tgt_sel and tgt_we.
  - ADDR: read → REQ next cycle. Write → REQ once DOE && any synced DS low.
  - REQ: tgt_req=1, timeout counter runs. tgt_ack[sel] → TERM. Counter == TIMEOUT_CYC-1 → TERM with timeout_flag set.
  - TERM: DTACK_OE=1, tgt_req=0. Sync FCS high → IDLE.
- SLAVE_n is low in ADDR, REQ and TERM.
- Sync FCS high in ADDR or REQ → IDLE immediately; tgt_req dropped; no DTACK.
- Ack and timeout in the same cycle: ack wins, flag not set. timeout_clr and set in the same cycle: set wins.
- Reset: all outputs deasserted (SLAVE_n=1, MTACK_n=1, DTACK_OE=0, tgt_req=0, tgt_sel=0, tgt_we=0, tgt_addr=0, tgt_be=0, timeout_flag=0, busy=0); state IDLE, from any state.

## Timing
- FCS_n edge to IDLE exit: SYNC_STAGES+1 cycles. ADDR→REQ for a read: 1 cycle.
- tgt_ack to DTACK_OE: 1 cycle. Sync FCS high to DTACK_OE=0: 1 cycle.
- Timeout: tgt_req asserted for exactly TIMEOUT_CYC cycles, then DTACK_OE the following cycle.
- tgt_addr, tgt_be and tgt_sel are stable from REQ entry until IDLE, or until the next ADDR in a burst.
- Counter width is clog2(TIMEOUT_CYC+1). The counter is cleared on every REQ entry and saturates; it never wraps.

## Configuration
- Z3_MULTI_XFER_EN defined:
  - MTACK_n is low with SLAVE_n.
  - In TERM with sync FCS low and sync MTCR_n low, all synced DS high releases DTACK_OE and returns to ADDR.
  - A[7:2] is resampled into tgt_addr; target and direction are kept.
- Z3_MULTI_XFER_EN undefined:
  - MTACK_n is tied 1 and MTCR_n is ignored.
  - One transfer per FCS cycle.

## Structure
- Package z3_slave_pkg holds:
  - the state enum (IDLE, ADDR, REQ, TERM)
  - TGT_BASE/TGT_MASK 8-bit tables, MAX_TGT=8
  - the valid-space function on FC
- Sub-module z3_sync: a SYNC_STAGES-deep, reset-to-1 synchroniser, instantiated for FCS_n, each DS_n bit and MTCR_n.

## Test plan
- Read, target 1 (TGT_BASE[1]=8'h01), base_addr=4'h8, A=32'h8010_0004: tgt_sel=4'b0010, tgt_addr=28'h010_0004, ack after 3 cycles → DTACK_OE 1 cycle later, released 1 cycle after FCS high.
- Write, DS_n=4'b0011 with DOE late by 5 cycles: tgt_req waits for DOE; tgt_be=4'b1100, tgt_we=1.
- No ack, TIMEOUT_CYC=16: tgt_req high 16 cycles, DTACK_OE follows, timeout_flag=1 until timeout_clr pulse.
- A[31:28]=4'h9 or configured=0: SLAVE_n, DTACK_OE, tgt_req stay inactive all cycle.
- IORST_n low during REQ: all outputs reset asynchronously; next valid FCS cycle completes normally.
- With Z3_MULTI_XFER_EN, 3 transfers at A[7:2]=0,1,2 under one FCS: three ack/DTACK pairs, tgt_addr low bits 0x0/0x4/0x8, MTACK_n low throughout.

Source files
------------

// File: rtl/z3_slave_pkg.sv
// z3_slave_pkg -- shared state encoding, target decode tables and helpers for
// the Zorro III slave cycle engine.
package z3_slave_pkg;

  localparam int MAX_TGT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    REQ  = 2'd2,
    TERM = 2'd3
  } z3_state_e;

  // Target windows on board offset A[27:20]: ROM, SCSI, SID, INTREG (8 slots), spares
  localparam logic [7:0] TGT_BASE [MAX_TGT] = '{8'h00, 8'h01, 8'h02, 8'h08,
                                                8'h10, 8'h11, 8'h12, 8'h13};
  localparam logic [7:0] TGT_MASK [MAX_TGT] = '{8'hFF, 8'hFF, 8'hFF, 8'hF8,
                                                8'hFF, 8'hFF, 8'hFF, 8'hFF};

  // Zorro III user/supervisor data or program space
  function automatic logic fc_valid(input logic [1:0] fc);
    return fc[1] ^ fc[0];
  endfunction

endpackage

// File: rtl/z3_sync.sv
// z3_sync -- STAGES-deep synchroniser for an asynchronous active-low strobe;
// resets to the inactive (high) level.
module z3_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sh;

  // Shift chain, idle-high out of reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh <= {STAGES{1'b1}};
    end else begin
      r_sh <= {r_sh[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sh[STAGES-1];

endmodule

// File: rtl/z3_slave_engine.sv
// z3_slave_engine -- claims Zorro III cycles in the board window, decodes them onto
// NUM_TGT req/ack targets and drives SLAVE_n/DTACK/MTACK. Optional: Z3_MULTI_XFER_EN.
module z3_slave_engine
  import z3_slave_pkg::*;
#(
  parameter int NUM_TGT     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               CLK_50M,
  input  logic               IORST_n,
  input  logic               FCS_n,
  input  logic [31:0]        A,
  input  logic [2:0]         FC,
  input  logic               READ,
  input  logic               DOE,
  input  logic [3:0]         DS_n,
  input  logic               MTCR_n,
  input  logic               configured,
  input  logic [3:0]         base_addr,
  output logic               SLAVE_n,
  output logic               DTACK_OE,
  output logic               MTACK_n,
  output logic [NUM_TGT-1:0] tgt_sel,
  output logic               tgt_req,
  output logic               tgt_we,
  output logic [27:0]        tgt_addr,
  output logic [3:0]         tgt_be,
  input  logic [NUM_TGT-1:0] tgt_ack,
  output logic               timeout_flag,
  input  logic               timeout_clr,
  output logic               busy
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [27:8]        r_addr_hi;
  logic               r_win_match;
  z3_state_e          r_state;
  z3_state_e          w_state_nx;
  logic               r_slave_n, r_dtack_oe, r_req, r_busy, r_we, r_to_flag;
  logic [NUM_TGT-1:0] r_sel;
  logic [27:0]        r_addr;
  logic [3:0]         r_be;
  logic [CW-1:0]      r_cnt;
  logic               w_fcs_n;
  logic [3:0]         w_ds_n;
  logic [NUM_TGT-1:0] w_match, w_dec_sel;
  logic               w_hit, w_ack, w_to_set, w_burst, w_unused;

  // Upper address and window match are frozen by the master's FCS_n fall
  always_ff @(negedge FCS_n or negedge IORST_n) begin
    if (!IORST_n) begin
      r_addr_hi   <= 20'h0_0000;
      r_win_match <= 1'b0;
    end else begin
      r_addr_hi   <= A[27:8];
      r_win_match <= (A[31:28] == base_addr) && configured && fc_valid(FC[1:0]);
    end
  end

  z3_sync #(.STAGES(SYNC_STAGES)) u_sync_fcs (
    .i_clk(CLK_50M), .i_rst_n(IORST_n), .i_d(FCS_n), .o_q(w_fcs_n)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_ds_sync
    z3_sync #(.STAGES(SYNC_STAGES)) u_sync_ds (
      .i_clk(CLK_50M), .i_rst_n(IORST_n), .i_d(DS_n[gi]), .o_q(w_ds_n[gi])
    );
  end

  // Per-target window hits; the lowest index is isolated below
  always_comb begin
    w_match = {NUM_TGT{1'b0}};
    for (int i = 0; i < NUM_TGT; i++) begin
      w_match[i] = ((r_addr_hi[27:20] & TGT_MASK[i]) == TGT_BASE[i]);
    end
  end

  assign w_dec_sel = w_match & (~w_match + NUM_TGT'(1));
  assign w_hit     = |w_match;
  assign w_ack     = |(tgt_ack & r_sel);

  // Next-state decode; a master releasing FCS always aborts back to IDLE
  always_comb begin
    w_state_nx = r_state;
    w_to_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fcs_n && r_win_match && w_hit) w_state_nx = ADDR;
        else                                  w_state_nx = IDLE;
      end
      ADDR: begin
        if (w_fcs_n)                             w_state_nx = IDLE;
        else if (!r_we || (DOE && !(&w_ds_n)))   w_state_nx = REQ;
        else                                     w_state_nx = ADDR;
      end
      REQ: begin
        if (w_fcs_n) begin
          w_state_nx = IDLE;
        end else if (w_ack) begin
          w_state_nx = TERM;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nx = TERM;
          w_to_set   = 1'b1;
        end else begin
          w_state_nx = REQ;
        end
      end
      TERM: begin
        if (w_fcs_n)      w_state_nx = IDLE;
        else if (w_burst) w_state_nx = ADDR;
        else              w_state_nx = TERM;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // State plus outputs registered from the next state so they align with it
  always_ff @(posedge CLK_50M or negedge IORST_n) begin
    if (!IORST_n) begin
      r_state    <= IDLE;
      r_slave_n  <= 1'b1;
      r_dtack_oe <= 1'b0;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_sel      <= {NUM_TGT{1'b0}};
      r_we       <= 1'b0;
      r_addr     <= 28'h000_0000;
      r_be       <= 4'b0000;
      r_cnt      <= {CW{1'b0}};
      r_to_flag  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_slave_n  <= (w_state_nx == IDLE);
      r_busy     <= (w_state_nx != IDLE);
      r_dtack_oe <= (w_state_nx == TERM);
      r_req      <= (w_state_nx == REQ);
      if (r_state == IDLE && w_state_nx == ADDR) begin
        r_sel <= w_dec_sel;
        r_we  <= !READ;
      end
      // Request payload is frozen on REQ entry; the counter only saturates
      if (r_state != REQ && w_state_nx == REQ) begin
        r_cnt  <= {CW{1'b0}};
        r_addr <= {r_addr_hi, A[7:2], 2'b00};
        r_be   <= ~w_ds_n;
      end else if (r_state == REQ && r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_to_set)         r_to_flag <= 1'b1;
      else if (timeout_clr) r_to_flag <= 1'b0;
    end
  end

`ifdef Z3_MULTI_XFER_EN
  logic w_mtcr_n;
  logic r_mtack_n;

  z3_sync #(.STAGES(SYNC_STAGES)) u_sync_mtcr (
    .i_clk(CLK_50M), .i_rst_n(IORST_n), .i_d(MTCR_n), .o_q(w_mtcr_n)
  );

  assign w_burst = !w_mtcr_n && (&w_ds_n);

  // MTACK_n tracks SLAVE_n for the whole claimed cycle
  always_ff @(posedge CLK_50M or negedge IORST_n) begin
    if (!IORST_n) r_mtack_n <= 1'b1;
    else          r_mtack_n <= (w_state_nx == IDLE);
  end

  assign MTACK_n  = r_mtack_n;
  assign w_unused = ^{A[1:0], FC[2]};
`else
  assign w_burst  = 1'b0;
  assign MTACK_n  = 1'b1;
  assign w_unused = ^{A[1:0], FC[2], MTCR_n};
`endif

  assign SLAVE_n      = r_slave_n;
  assign DTACK_OE     = r_dtack_oe;
  assign tgt_sel      = r_sel;
  assign tgt_req      = r_req;
  assign tgt_we       = r_we;
  assign tgt_addr     = r_addr;
  assign tgt_be       = r_be;
  assign timeout_flag = r_to_flag;
  assign busy         = r_busy;

endmodule

// File: tb/tb_z3_slave_engine.sv
// tb_z3_slave_engine -- vector table, randomized transfers against a decode/timing
// reference model, and hand-written reset/abort/burst sequences.
module tb_z3_slave_engine;
  import z3_slave_pkg::*;

  localparam int NT = 4;
  localparam int SS = 2;
  localparam int TO = 16;
`ifdef Z3_MULTI_XFER_EN
  localparam logic EXP_MTACK = 1'b0;
`else
  localparam logic EXP_MTACK = 1'b1;
`endif

  logic CLK_50M = 1'b0;
  logic IORST_n, FCS_n, READ, DOE, MTCR_n, configured, timeout_clr;
  logic [31:0] A;
  logic [2:0] FC;
  logic [3:0] DS_n, base_addr, tgt_be;
  logic SLAVE_n, DTACK_OE, MTACK_n, tgt_req, tgt_we, timeout_flag, busy;
  logic [NT-1:0] tgt_sel, tgt_ack;
  logic [27:0] tgt_addr;

  always #10 CLK_50M = ~CLK_50M;

  z3_slave_engine #(.NUM_TGT(NT), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)) dut (
    .CLK_50M(CLK_50M), .IORST_n(IORST_n), .FCS_n(FCS_n), .A(A), .FC(FC), .READ(READ),
    .DOE(DOE), .DS_n(DS_n), .MTCR_n(MTCR_n), .configured(configured), .base_addr(base_addr),
    .SLAVE_n(SLAVE_n), .DTACK_OE(DTACK_OE), .MTACK_n(MTACK_n), .tgt_sel(tgt_sel),
    .tgt_req(tgt_req), .tgt_we(tgt_we), .tgt_addr(tgt_addr), .tgt_be(tgt_be),
    .tgt_ack(tgt_ack), .timeout_flag(timeout_flag), .timeout_clr(timeout_clr), .busy(busy)
  );

  typedef struct {
    logic [31:0]   addr;
    logic [2:0]    fc;
    logic          rd;
    logic [3:0]    dsn;
    logic          cfg;
    logic [3:0]    base;
    int            doe_dly;
    int            ack_dly;   // 0: never acknowledge
    logic          clr_last;  // pulse timeout_clr in the final REQ cycle
    logic [NT-1:0] exp_sel;   // 0: cycle must not be claimed
    logic [27:0]   exp_addr;
    logic [3:0]    exp_be;
    logic          exp_to;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[12];
  vec_t rv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK_50M);
    #2;
  endtask

  // Reference decode: window, function-code space, then first matching target
  function automatic logic [NT-1:0] ref_sel(input logic [31:0] a, input logic [2:0] fc,
                                            input logic cfg, input logic [3:0] base);
    if (!cfg || a[31:28] != base || !(fc[1:0] inside {2'b01, 2'b10})) return '0;
    for (int i = 0; i < NT; i++)
      if ((a[27:20] & TGT_MASK[i]) == TGT_BASE[i]) return NT'(1) << i;
    return '0;
  endfunction

  task automatic idle_gap();
    FCS_n = 1'b1; DS_n = 4'hF; DOE = 1'b0; tgt_ack = '0;
    cyc(); cyc(); cyc();
  endtask

  task automatic xfer(input vec_t v);
    int n;
    A = v.addr; FC = v.fc; READ = v.rd; configured = v.cfg; base_addr = v.base;
    DS_n = v.dsn; DOE = v.rd; tgt_ack = '0;
    FCS_n = 1'b0;
    cyc(); cyc();
    chk("slave_early", SLAVE_n, 1'b1);
    cyc();
    if (v.exp_sel == '0) begin
      for (int k = 0; k < 8; k++) begin
        chk("unclaimed", {SLAVE_n, DTACK_OE, tgt_req, busy}, 4'b1000);
        cyc();
      end
    end else begin
      chk("claim_slave", {SLAVE_n, busy}, 2'b01);
      chk("claim_mtack", MTACK_n, EXP_MTACK);
      chk("claim_sel", tgt_sel, v.exp_sel);
      chk("claim_we", tgt_we, !v.rd);
      if (!v.rd) begin
        for (int k = 0; k < v.doe_dly; k++) begin
          cyc();
          chk("req_wait_doe", tgt_req, 1'b0);
        end
        DOE = 1'b1;
      end
      cyc();
      chk("req_on", tgt_req, 1'b1);
      chk("req_addr", tgt_addr, v.exp_addr);
      chk("req_be", tgt_be, v.exp_be);
      chk("req_sel", tgt_sel, v.exp_sel);
      if (v.ack_dly > 0) begin
        for (int k = 1; k < v.ack_dly; k++) begin
          cyc();
          chk("req_hold", {tgt_req, DTACK_OE}, 2'b10);
        end
        tgt_ack = v.exp_sel;
        cyc();
        chk("dtack_on", {DTACK_OE, tgt_req}, 2'b10);
        tgt_ack = '0;
      end else begin
        n = 1;
        while (n < 2 * TO) begin
          if (v.clr_last && n == TO) timeout_clr = 1'b1;
          cyc();
          timeout_clr = 1'b0;
          if (!tgt_req) break;
          n++;
        end
        chk("req_len", n, TO);
        chk("dtack_to", DTACK_OE, 1'b1);
      end
      chk("to_flag", timeout_flag, v.exp_to);
      cyc();
      chk("dtack_hold", DTACK_OE, 1'b1);
      FCS_n = 1'b1; DS_n = 4'hF; DOE = 1'b0;
      cyc(); cyc();
      chk("dtack_before_idle", DTACK_OE, 1'b1);
      cyc();
      chk("release", {DTACK_OE, SLAVE_n, busy, tgt_req}, 4'b0100);
      if (v.exp_to) begin
        chk("to_sticky", timeout_flag, 1'b1);
        timeout_clr = 1'b1; cyc(); timeout_clr = 1'b0;
        chk("to_clr", timeout_flag, 1'b0);
      end
    end
    idle_gap();
  endtask

  task automatic start_read();
    A = 32'h8010_0004; FC = 3'b001; READ = 1'b1; DS_n = 4'h0; DOE = 1'b1;
    configured = 1'b1; base_addr = 4'h8; FCS_n = 1'b0;
    for (int k = 0; k < 10 && !tgt_req; k++) cyc();
    chk("start_reach_req", tgt_req, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    IORST_n = 1'b0; FCS_n = 1'b1; A = 32'h0; FC = 3'b000; READ = 1'b1; DOE = 1'b0;
    DS_n = 4'hF; MTCR_n = 1'b1; configured = 1'b0; base_addr = 4'h0;
    tgt_ack = '0; timeout_clr = 1'b0;
    cyc(); cyc(); cyc();
    chk("reset_ctl", {SLAVE_n, MTACK_n, DTACK_OE, tgt_req, tgt_we, timeout_flag, busy, tgt_sel, tgt_be},
        {7'b1100000, 8'h00});
    chk("reset_addr", tgt_addr, 28'h0);
    IORST_n = 1'b1;
    cyc(); cyc();

    vecs[0]  = '{32'h8010_0004, 3'b001, 1'b1, 4'b0000, 1'b1, 4'h8, 0, 3,  1'b0, 4'b0010, 28'h010_0004, 4'b1111, 1'b0};
    vecs[1]  = '{32'h8020_0010, 3'b010, 1'b0, 4'b0011, 1'b1, 4'h8, 5, 2,  1'b0, 4'b0100, 28'h020_0010, 4'b1100, 1'b0};
    vecs[2]  = '{32'h8000_00FC, 3'b110, 1'b1, 4'b0000, 1'b1, 4'h8, 0, 0,  1'b0, 4'b0001, 28'h000_00FC, 4'b1111, 1'b1};
    vecs[3]  = '{32'h9010_0004, 3'b001, 1'b1, 4'b0000, 1'b1, 4'h8, 0, 3,  1'b0, 4'b0000, 28'h0,        4'b1111, 1'b0};
    vecs[4]  = '{32'h8010_0004, 3'b001, 1'b1, 4'b0000, 1'b0, 4'h8, 0, 3,  1'b0, 4'b0000, 28'h0,        4'b1111, 1'b0};
    vecs[5]  = '{32'h8010_0004, 3'b011, 1'b1, 4'b0000, 1'b1, 4'h8, 0, 3,  1'b0, 4'b0000, 28'h0,        4'b1111, 1'b0};
    vecs[6]  = '{32'h8030_0000, 3'b001, 1'b1, 4'b0000, 1'b1, 4'h8, 0, 3,  1'b0, 4'b0000, 28'h0,        4'b1111, 1'b0};
    vecs[7]  = '{32'h80C0_0040, 3'b101, 1'b1, 4'b0110, 1'b1, 4'h8, 0, 1,  1'b0, 4'b1000, 28'h0C0_0040, 4'b1001, 1'b0};
    vecs[8]  = '{32'h8010_0008, 3'b001, 1'b1, 4'b0000, 1'b1, 4'h8, 0, TO, 1'b0, 4'b0010, 28'h010_0008, 4'b1111, 1'b0};
    vecs[9]  = '{32'h8000_1000, 3'b010, 1'b0, 4'b1110, 1'b1, 4'h8, 0, 0,  1'b1, 4'b0001, 28'h000_1000, 4'b0001, 1'b1};
    vecs[10] = '{32'h8010_0004, 3'b100, 1'b1, 4'b0000, 1'b1, 4'h8, 0, 3,  1'b0, 4'b0000, 28'h0,        4'b1111, 1'b0};
    vecs[11] = '{32'hA010_0004, 3'b001, 1'b1, 4'b0000, 1'b1, 4'hA, 0, 2,  1'b0, 4'b0010, 28'h010_0004, 4'b1111, 1'b0};
    for (int i = 0; i < 12; i++) xfer(vecs[i]);

    for (int r = 0; r < 40; r++) begin
      rv.base = 4'($urandom_range(1, 15));
      rv.addr = $urandom;
      rv.addr[31:28] = ($urandom_range(0, 3) != 0) ? rv.base : 4'($urandom);
      rv.addr[27:20] = 8'($urandom_range(0, 20));
      rv.fc = 3'($urandom);
      rv.rd = 1'($urandom);
      rv.dsn = 4'($urandom_range(0, 14));
      rv.cfg = ($urandom_range(0, 7) != 0);
      rv.doe_dly = $urandom_range(0, 3);
      rv.ack_dly = $urandom_range(1, 6);
      rv.clr_last = 1'b0;
      rv.exp_sel = ref_sel(rv.addr, rv.fc, rv.cfg, rv.base);
      rv.exp_addr = {rv.addr[27:2], 2'b00};
      rv.exp_be = ~rv.dsn;
      rv.exp_to = 1'b0;
      xfer(rv);
    end

    // Asynchronous reset in the middle of a request
    start_read();
    #3 IORST_n = 1'b0;
    #1;
    chk("rst_async_ctl", {SLAVE_n, MTACK_n, DTACK_OE, tgt_req, tgt_we, timeout_flag, busy, tgt_sel, tgt_be},
        {7'b1100000, 8'h00});
    chk("rst_async_addr", tgt_addr, 28'h0);
    FCS_n = 1'b1; DS_n = 4'hF;
    cyc(); cyc();
    IORST_n = 1'b1;
    cyc(); cyc(); cyc();
    xfer(vecs[0]);

    // Master abandons the cycle while the request is outstanding
    start_read();
    FCS_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("abort_no_dtack", DTACK_OE, 1'b0);
    end
    chk("abort_idle", {SLAVE_n, tgt_req, busy}, 3'b100);
    idle_gap();

`ifdef Z3_MULTI_XFER_EN
    A = 32'h8010_0000; FC = 3'b001; READ = 1'b1; DS_n = 4'h0; DOE = 1'b1;
    configured = 1'b1; base_addr = 4'h8; MTCR_n = 1'b0; FCS_n = 1'b0;
    for (int x = 0; x < 3; x++) begin
      for (int k = 0; k < 20 && !tgt_req; k++) cyc();
      chk("mx_req", tgt_req, 1'b1);
      chk("mx_addr", tgt_addr[7:0], 8'(4 * x));
      chk("mx_mtack", MTACK_n, 1'b0);
      tgt_ack = 4'b0010;
      cyc();
      chk("mx_dtack", DTACK_OE, 1'b1);
      tgt_ack = '0;
      DS_n = 4'hF;
      for (int k = 0; k < 20 && DTACK_OE; k++) cyc();
      chk("mx_release", {DTACK_OE, SLAVE_n, MTACK_n}, 3'b000);
      A[7:2] = 6'(x + 1);
      DS_n = 4'h0;
    end
    MTCR_n = 1'b1;
    FCS_n = 1'b1; DS_n = 4'hF;
    cyc(); cyc(); cyc(); cyc();
    chk("mx_end", {SLAVE_n, MTACK_n, DTACK_OE, tgt_req}, 4'b1100);
    idle_gap();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
